xnor_pattern_detector: RTL and testbench
========================================

# xnor_pattern_detector

Parametrised serial pattern detector built on per-bit XNOR comparison. It shifts a one-bit stream into a WIDTH-deep history register and compares it against a programmable pattern under a per-bit care mask. On a match it emits a one-cycle hit pulse and increments a saturating hit counter. It sits after bit-serial receive logic as the sequential successor to the 2-input XNOR gate cell, generalised to WIDTH bits with masking, overlap mode and hit counting.

## Interface
- WIDTH, 8: pattern length in bits; legal range 2..32.
- CNT_W, 8: hit counter width; legal range 1..32.
- SCORE_W, $clog2(WIDTH+1): score output width (derived; do not override).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit is accepted this cycle.
- in_bit  input  1  serial data; the pattern MSB arrives first.
- pattern  input  WIDTH  target sequence; pattern[WIDTH-1] is compared with the oldest bit.
- mask  input  WIDTH  1 = compare this bit, 0 = don't care.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clear  input  1  synchronous clear of history, fill and counter.
- hit  output  1  one-cycle match pulse.
- hit_count  output  CNT_W  saturating number of hits.
- fill_done  output  1  history holds WIDTH valid bits.
- score  output  SCORE_W  count of matching masked bits (see Configuration).

## Operation
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- History register sr[WIDTH-1:0]: on accept (in_valid=1, clear=0), next_sr = {sr[WIDTH-2:0], in_bit}. No shift without accept.
- Fill counter: 0..WIDTH.
  - Increments on each accept and saturates at WIDTH.
  - A cycle is eligible when the fill count after this accept equals WIDTH.
- Match: match = AND over i of (mask[i]==0 OR next_sr[i] XNOR pattern[i]).
  - If mask is all zeros, every eligible accept matches.
- Hit: hit <= eligible & match on accept; otherwise hit <= 0.
- Counter: hit_count increments on each hit and saturates at 2^CNT_W-1. It never wraps.
- overlap=0: on a hit, fill is set to 0, so WIDTH fresh bits are required before the next hit. sr still shifts normally.
- overlap=1: fill stays at WIDTH, so consecutive accepts can hit on consecutive cycles.
- pattern, mask and overlap are sampled in the accept cycle and may change mid-stream. No re-arm is needed.
- clear: has priority over in_valid in the same cycle.
  - sr, fill, hit_count, hit and score go to 0.
  - in_bit is discarded.
- fill_done = (fill == WIDTH), taken from the registered fill value.

## Timing
- All outputs are registered. Reset value of hit, hit_count, fill_done and score is 0; sr and fill also reset to 0.
- Reset is asynchronous: outputs go to 0 immediately on rst_n falling, even mid-stream. Operation resumes on the first rising clk edge after rst_n rises.
- Latency: a hit appears on the clock edge that accepts the WIDTH-th matching bit and is visible the cycle after in_valid. hit_count updates on the same edge as hit.
- hit is high for exactly one cycle per matching accept. With in_valid gaps, hit is 0 during non-accept cycles.
- fill_done rises on the same edge as the WIDTH-th accept. With overlap=0 it falls on the edge that produces a hit.

## Configuration
- XNOR_PD_SCORE_EN defined: score <= popcount over i of (mask[i] & (next_sr[i] XNOR pattern[i])) on every accept, regardless of eligibility. score is held otherwise and cleared by clear or reset.
- XNOR_PD_SCORE_EN undefined: the score port still exists and is tied to 0, and no popcount logic is synthesised. hit, hit_count and fill_done behaviour is identical in both cases.

## Test plan
- Basic match: WIDTH=8, pattern=8'hA5, mask=8'hFF, overlap=1; feed 1,0,1,0,0,1,0,1 with in_valid=1 -> hit=1 for one cycle after the 8th bit, hit_count=1, fill_done=1 after the 8th bit.
- Overlap modes: pattern=8'hFF, feed 10 ones.
  - overlap=1 -> hits after bits 8, 9 and 10; hit_count=3.
  - overlap=0 -> one hit after bit 8; hit_count=1; fill_done=0 after the hit.
- Masking and gaps: pattern=8'h05, mask=8'h0F; feed 8'hF5 with in_valid toggling every other cycle -> one hit after the 8th accepted bit, none in idle cycles; hit_count=1.
- Saturation: CNT_W=2, overlap=1, pattern=8'h00, mask=8'h00; 12 accepts -> 5 hits, hit_count holds at 3.
- Clear and reset:
  - clear=1 with in_valid=1 mid-stream -> the bit is discarded; hit_count=0, fill_done=0 the next cycle.
  - rst_n pulsed low between clock edges -> all outputs 0 immediately.
- Score (with XNOR_PD_SCORE_EN): pattern=8'hA5, mask=8'hFF.
  - Stream 8'h5A -> score=0 and no hit.
  - Stream 8'hA4 -> score=7 and no hit.
  - Without the macro -> score=0 throughout.

Source files
------------

// File: rtl/xnor_pattern_detector.sv
// xnor_pattern_detector: serial pattern detector using per-bit XNOR comparison.
// A one-bit stream is shifted into a WIDTH-deep history and compared against a
// programmable pattern under a care mask. Each match pulses hit for one cycle
// and bumps a saturating hit counter. Overlapping and non-overlapping detection
// are both supported.
// Optional feature: define XNOR_PD_SCORE_EN to enable the masked-match score
// (popcount) output. When it is not defined, score is tied to zero.
module xnor_pattern_detector #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  parameter int SCORE_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic [WIDTH-1:0]   pattern,
  input  logic [WIDTH-1:0]   mask,
  input  logic               overlap,
  input  logic               clear,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_count,
  output logic               fill_done,
  output logic [SCORE_W-1:0] score
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [WIDTH-1:0]  sr;
  logic [WIDTH-1:0]  next_sr;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_acc;
  logic [FILL_W-1:0] fill_next;
  logic              accept;
  logic              eligible;
  logic              match;
  logic              hit_now;

  // Decode this cycle's accept: shifted history, fill update and match result.
  always_comb begin
    accept    = in_valid & ~clear;
    next_sr   = {sr[WIDTH-2:0], in_bit};
    fill_acc  = (fill == FULL) ? FULL : fill + FILL_W'(1);
    eligible  = (fill_acc == FULL);
    match     = &(~mask | ~(next_sr ^ pattern));
    hit_now   = accept & eligible & match;
    // Non-overlapping mode restarts the fill so WIDTH fresh bits are needed.
    fill_next = (hit_now & ~overlap) ? '0 : fill_acc;
  end

  // History, fill, hit pulse and saturating counter; clear beats in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      fill      <= '0;
      hit       <= 1'b0;
      hit_count <= '0;
    end else if (clear) begin
      sr        <= '0;
      fill      <= '0;
      hit       <= 1'b0;
      hit_count <= '0;
    end else if (accept) begin
      sr   <= next_sr;
      fill <= fill_next;
      hit  <= hit_now;
      if (hit_now && (hit_count != CNT_MAX)) begin
        hit_count <= hit_count + CNT_W'(1);
      end
    end else begin
      hit <= 1'b0;
    end
  end

  assign fill_done = (fill == FULL);

`ifdef XNOR_PD_SCORE_EN
  logic [SCORE_W-1:0] score_next;
  logic [SCORE_W-1:0] score_q;

  // Popcount of masked bit positions that agree with the pattern.
  always_comb begin
    score_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      score_next = score_next + SCORE_W'(mask[i] & ~(next_sr[i] ^ pattern[i]));
    end
  end

  // Score updates on every accept, regardless of eligibility, and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else if (clear) begin
      score_q <= '0;
    end else if (accept) begin
      score_q <= score_next;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_xnor_pattern_detector.sv
// Bench for xnor_pattern_detector: a default-parameter instance and a CNT_W=2
// instance share one stimulus stream. A reference model pushes expected
// outputs to a queue per driven cycle; they are popped and compared after the
// clock edge. Directed checks cover the key scenarios.
module tb_xnor_pattern_detector;

  typedef struct {
    logic       hit;
    int         cnt;
    int         cnt2;
    logic       fdone;
    int         score;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic [7:0] pattern = '0;
  logic [7:0] mask = '0;
  logic       overlap = 1'b0;
  logic       clear = 1'b0;

  logic       hit, hit2;
  logic [7:0] hit_count;
  logic [1:0] hit_count2;
  logic       fill_done, fill_done2;
  logic [3:0] score, score2;

  int checks = 0;
  int failures = 0;

  exp_t q[$];

  // Reference model state.
  logic [7:0] m_sr;
  int         m_fill, m_cnt, m_cnt2, m_score;
  logic       m_hit;

  xnor_pattern_detector #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .pattern(pattern), .mask(mask), .overlap(overlap), .clear(clear),
    .hit(hit), .hit_count(hit_count), .fill_done(fill_done), .score(score)
  );

  xnor_pattern_detector #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .pattern(pattern), .mask(mask), .overlap(overlap), .clear(clear),
    .hit(hit2), .hit_count(hit_count2), .fill_done(fill_done2), .score(score2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sr = '0; m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_score = 0; m_hit = 1'b0;
  endtask

  // Independent behavioural reference for one clock edge.
  task automatic model_step(input logic v, input logic b, input logic clr);
    logic [7:0] nsr;
    int nf, pc;
    logic mt;
    if (clr) begin
      model_reset();
    end else if (v) begin
      nsr = {m_sr[6:0], b};
      nf = (m_fill < 8) ? m_fill + 1 : 8;
      mt = 1'b1;
      pc = 0;
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) begin
          if (nsr[i] != pattern[i]) mt = 1'b0;
          else pc++;
        end
      end
      m_hit = (nf == 8) && mt;
      if (m_hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!overlap) nf = 0;
      end
      m_fill = nf;
      m_sr = nsr;
`ifdef XNOR_PD_SCORE_EN
      m_score = pc;
`else
      m_score = 0;
`endif
    end else begin
      m_hit = 1'b0;
    end
  endtask

  // Drive one cycle, queue the expectation, then pop and compare after the edge.
  task automatic step(input logic v, input logic b, input logic clr);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_bit = b; clear = clr;
    model_step(v, b, clr);
    q.push_back('{hit: m_hit, cnt: m_cnt, cnt2: m_cnt2,
                  fdone: (m_fill == 8), score: m_score});
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("sb_hit", int'(hit), int'(e.hit));
    chk("sb_cnt", int'(hit_count), e.cnt);
    chk("sb_cnt2", int'(hit_count2), e.cnt2);
    chk("sb_fill_done", int'(fill_done), int'(e.fdone));
    chk("sb_score", int'(score), e.score);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] val);
    for (int i = 7; i >= 0; i--) step(1'b1, val[i], 1'b0);
  endtask

  initial begin
    logic [7:0] bits;
    model_reset();
    #12;
    chk("rst_hit", int'(hit), 0);
    chk("rst_cnt", int'(hit_count), 0);
    chk("rst_fill_done", int'(fill_done), 0);
    chk("rst_score", int'(score), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic match, A5 fully compared.
    pattern = 8'hA5; mask = 8'hFF; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    bits = 8'hA5;
    for (int i = 7; i >= 1; i--) step(1'b1, bits[i], 1'b0);
    chk("basic_pre_hit", int'(hit), 0);
    chk("basic_pre_fill", int'(fill_done), 0);
    step(1'b1, bits[0], 1'b0);
    chk("basic_hit", int'(hit), 1);
    chk("basic_cnt", int'(hit_count), 1);
    chk("basic_fill", int'(fill_done), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("basic_pulse_end", int'(hit), 0);

    // Overlapping: ten ones against FF -> three hits.
    pattern = 8'hFF; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
    chk("ovl1_cnt", int'(hit_count), 3);
    chk("ovl1_hit_last", int'(hit), 1);

    // Non-overlapping: one hit, fill restarts.
    overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
    chk("ovl0_hit", int'(hit), 1);
    chk("ovl0_fill_after_hit", int'(fill_done), 0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("ovl0_cnt", int'(hit_count), 1);
    chk("ovl0_no_hit", int'(hit), 0);

    // Masked low nibble with in_valid gaps.
    pattern = 8'h05; mask = 8'h0F; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    bits = 8'hF5;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      if (i == 0) chk("gap_hit", int'(hit), 1);
      step(1'b0, 1'b1, 1'b0);
      chk("gap_idle_hit", int'(hit), 0);
    end
    chk("gap_cnt", int'(hit_count), 1);

    // Saturation: all don't-care, twelve accepts -> five hits.
    pattern = 8'h00; mask = 8'h00; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, i[0], 1'b0);
    chk("sat_cnt2", int'(hit_count2), 3);
    chk("sat_cnt", int'(hit_count), 5);

    // Clear with in_valid mid-stream discards the bit.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_cnt", int'(hit_count), 0);
    chk("clr_fill", int'(fill_done), 0);
    chk("clr_hit", int'(hit), 0);

    // Asynchronous reset between edges, with outputs active.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
    chk("pre_arst_cnt", int'(hit_count), 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_hit", int'(hit), 0);
    chk("arst_cnt", int'(hit_count), 0);
    chk("arst_fill", int'(fill_done), 0);
    chk("arst_score", int'(score), 0);
    #1 rst_n = 1'b1;

    // Score: inverted pattern and a single-bit miss.
    pattern = 8'hA5; mask = 8'hFF; overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    feed_byte(8'h5A);
    chk("score_5a", int'(score), 0);
    chk("score_5a_hit", int'(hit), 0);
    step(1'b0, 1'b0, 1'b1);
    feed_byte(8'hA4);
`ifdef XNOR_PD_SCORE_EN
    chk("score_a4", int'(score), 7);
`else
    chk("score_a4", int'(score), 0);
`endif
    chk("score_a4_hit", int'(hit), 0);
    chk("q_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
